// File: rtl/wimax_interleaver_pp.sv
// wimax_interleaver_pp
// Ping-pong WiMAX (802.16) block interleaver for QPSK / 16-QAM / 64-QAM.
// Coded bits are written into one bank at their permuted address while the
// other bank drains in linear order, so both sides can stream at one bit
// per clock.
// Optional build macro: WIMAX_INTLV_BYPASS_EN adds a `bypass` input that,
// when latched high at the first bit of a block, stores that block unpermuted.
//
// Bank state | meaning
// -----------+----------------------------------------------------------
// EMPTY      | no data; may be selected as the next write bank
// FILLING    | write side has accepted at least one bit of the block
// FULL       | block complete; drained by the read side, oldest first
module wimax_interleaver_pp #(
  parameter int N_CARRIERS = 96,
  parameter int D          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mod_sel,
`ifdef WIMAX_INTLV_BYPASS_EN
  input  logic       bypass,
`endif
  input  logic       in_valid,
  input  logic       in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic       out_data,
  output logic       out_last,
  output logic [1:0] out_mod,
  input  logic       out_ready
);

  localparam int NCBPS_MAX = 6 * N_CARRIERS;
  localparam int IW        = $clog2(NCBPS_MAX);
  localparam int AW        = IW + 4;

  // Per-mode block sizes and row counts, pre-sized for the address datapath.
  localparam logic [AW-1:0] NC_16   = AW'(4 * N_CARRIERS);
  localparam logic [AW-1:0] NC_64   = AW'(6 * N_CARRIERS);
  localparam logic [AW-1:0] ROWS_Q  = AW'(2 * N_CARRIERS / D);
  localparam logic [AW-1:0] ROWS_16 = AW'(4 * N_CARRIERS / D);
  localparam logic [AW-1:0] ROWS_64 = AW'(6 * N_CARRIERS / D);
  localparam logic [AW-1:0] D_W     = AW'(D);
  localparam logic [AW-1:0] THREE   = AW'(3);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  bank_state_t          bank_st   [2];
  logic [1:0]           bank_mode [2];
  logic [NCBPS_MAX-1:0] bank_mem  [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [IW-1:0]        wr_k;
  logic [IW-1:0]        rd_r;

  logic                 in_fire;
  logic                 out_fire;
  logic                 wr_first;
  logic                 wr_last;
  logic                 rd_last;
  logic [1:0]           wr_mode;
  logic                 wr_byp;
  logic [IW-1:0]        j_idx;

  logic [AW-1:0]        k_w;
  logic [AW-1:0]        rows_w;
  logic [AW-1:0]        m_w;
  logic [AW-1:0]        fl_w;
  logic [AW-1:0]        t_w;
  logic [AW-1:0]        j_w;

  // Final bit index of a block for a given mode; reserved mode behaves as QPSK.
  function automatic logic [IW-1:0] last_idx(input logic [1:0] mode);
    case (mode)
      2'b01:   last_idx = IW'(4 * N_CARRIERS - 1);
      2'b10:   last_idx = IW'(6 * N_CARRIERS - 1);
      default: last_idx = IW'(2 * N_CARRIERS - 1);
    endcase
  endfunction

  // Write side may proceed whenever its bank has not yet been handed to the reader.
  assign in_ready = (bank_st[wr_ptr] != BANK_FULL);
  assign in_fire  = in_valid && in_ready;
  assign wr_first = (wr_k == '0);

  // Mode for the bit being written comes straight from mod_sel on the first
  // bit, so the address of k=0 already uses the block's own mode.
  assign wr_mode  = wr_first ? mod_sel : bank_mode[wr_ptr];
  assign wr_last  = (wr_k == last_idx(wr_mode));

  assign out_valid = (bank_st[rd_ptr] == BANK_FULL);
  assign out_fire  = out_valid && out_ready;
  assign rd_last   = (rd_r == last_idx(bank_mode[rd_ptr]));

  assign out_data  = out_valid & bank_mem[rd_ptr][rd_r];
  assign out_last  = out_valid & rd_last;
  assign out_mod   = out_valid ? bank_mode[rd_ptr] : 2'b00;

`ifdef WIMAX_INTLV_BYPASS_EN
  logic bank_byp [2];

  assign wr_byp = wr_first ? bypass : bank_byp[wr_ptr];

  // Bypass flag is latched per bank together with the mode on the first bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_byp[0] <= 1'b0;
      bank_byp[1] <= 1'b0;
    end else if (in_fire && wr_first) begin
      bank_byp[wr_ptr] <= bypass;
    end
  end
`else
  assign wr_byp = 1'b0;
`endif

  // Two-step 802.16 permutation of write index k into bank address j.
  always_comb begin
    k_w = AW'(wr_k);
    case (wr_mode)
      2'b01:   rows_w = ROWS_16;
      2'b10:   rows_w = ROWS_64;
      default: rows_w = ROWS_Q;
    endcase
    m_w  = rows_w * (k_w % D_W) + k_w / D_W;
    fl_w = '0;
    t_w  = '0;
    j_w  = m_w;
    case (wr_mode)
      2'b01: begin
        // s = 2: keep the even base of m, pick the bit within the pair
        fl_w = (D_W * m_w) / NC_16;
        t_w  = m_w + NC_16 - fl_w;
        j_w  = {m_w[AW-1:1], 1'b0} + {{(AW-1){1'b0}}, t_w[0]};
      end
      2'b10: begin
        // s = 3: rotate within each group of three
        fl_w = (D_W * m_w) / NC_64;
        t_w  = m_w + NC_64 - fl_w;
        j_w  = THREE * (m_w / THREE) + (t_w % THREE);
      end
      default: begin
        // s = 1: second step is the identity
        j_w = m_w;
      end
    endcase
    if (wr_byp) begin
      j_w = k_w;
    end
  end

  assign j_idx = IW'(j_w);

  // Bank storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      bank_mem[wr_ptr][j_idx] <= in_data;
    end
  end

  // Bank state, pointers and counters; write and read always target
  // different banks, so both completions in one cycle are independent.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_st[0]   <= BANK_EMPTY;
      bank_st[1]   <= BANK_EMPTY;
      bank_mode[0] <= 2'b00;
      bank_mode[1] <= 2'b00;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      wr_k         <= '0;
      rd_r         <= '0;
    end else begin
      if (in_fire) begin
        if (wr_first) begin
          bank_mode[wr_ptr] <= mod_sel;
        end
        if (wr_last) begin
          bank_st[wr_ptr] <= BANK_FULL;
          wr_k            <= '0;
          wr_ptr          <= ~wr_ptr;
        end else begin
          bank_st[wr_ptr] <= BANK_FILLING;
          wr_k            <= wr_k + 1'b1;
        end
      end
      if (out_fire) begin
        if (rd_last) begin
          bank_st[rd_ptr] <= BANK_EMPTY;
          rd_r            <= '0;
          rd_ptr          <= ~rd_ptr;
        end else begin
          rd_r <= rd_r + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/wimax_interleaver_pp.md
# wimax_interleaver_pp

Parametrised, mode-switchable WiMAX block interleaver that sits between the FEC encoder and the modulator. It accepts a serial coded-bit stream, applies the 802.16 two-step permutation for QPSK, 16-QAM or 64-QAM blocks, and emits the permuted block serially. Ping-pong storage lets one block fill while the previous block drains, so full-rate streaming needs no stalls. Valid/ready handshakes apply on both sides.

## Interface
- N_CARRIERS, 96, data subcarriers per symbol; must be a multiple of 8. Ncbps = N_CARRIERS × Ncpc.
- D, 16, interleaver column count (d); N_CARRIERS × 2 must be divisible by D.
- NCBPS_MAX, 6×N_CARRIERS, derived: bank size in bits. IW = clog2(NCBPS_MAX).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- mod_sel  in  2  mode: 00 QPSK (Ncpc=2), 01 16-QAM (Ncpc=4), 10 64-QAM (Ncpc=6), 11 reserved (treated as QPSK).
- in_valid  in  1  FEC bit valid.
- in_data  in  1  coded bit.
- in_ready  out  1  interleaver can accept a bit.
- out_valid  out  1  out_data holds a valid permuted bit.
- out_data  out  1  permuted bit; 0 while out_valid=0.
- out_last  out  1  high with the final bit of a block.
- out_mod  out  2  mod_sel latched for the block being drained.
- out_ready  in  1  modulator accepts out_data.

## Operation
- Two banks of NCBPS_MAX bits. Each bank is in one of three states: EMPTY, FILLING or FULL. A bank in FULL is the drain bank.
- Write side: counter k runs 0..Ncbps−1 on the current write bank. An input transfer occurs when in_valid && in_ready.
- When k=0 is accepted, mod_sel is latched per bank, fixing Ncbps, Ncpc and s = Ncpc/2 for the whole block. Changes to mod_sel mid-block are ignored.
- Each accepted bit is stored at bank[j], where:
  - m = (Ncbps/D)·(k mod D) + floor(k/D)
  - j = s·floor(m/s) + ((m + Ncbps − floor(D·m/Ncbps)) mod s)
  - All intermediate terms use unsigned IW+4-bit arithmetic; the result is always < Ncbps.
- On accepting k = Ncbps−1, the bank goes FULL, k resets to 0, and the write pointer toggles to the other bank.
- in_ready = 1 when the write bank is EMPTY or FILLING. It is 0 when both banks are FULL.
- Read side: counter r runs 0..Ncbps(block)−1 over the oldest FULL bank.
  - out_valid = 1 while a bank is FULL.
  - out_data = bank[r].
  - out_last = (r == Ncbps−1).
  - out_mod = that bank's latched mode.
- An output transfer occurs when out_valid && out_ready. On the transfer with out_last, the bank goes EMPTY, r resets to 0, and the read pointer toggles.
- Simultaneous events:
  - The last-bit write to one bank and the last-bit read of the other in the same cycle are both honoured.
  - If both banks are FULL, a read completion frees a bank; in_ready rises the following cycle.
- Reset values:
  - Both banks EMPTY; k=0, r=0; write and read pointers both on bank 0.
  - in_ready=1, out_valid=0, out_data=0, out_last=0, out_mod=00.
  - Bank contents are not reset.
- A reset mid-block discards all partial and stored blocks.

## Timing
- Latency: when the last bit of a block is accepted in cycle T, out_valid=1 in cycle T+1 with the block's first permuted bit.
- Throughput: one bit per cycle each side. Continuous in_valid and out_ready produce no bubbles after the first block.
- out_data, out_last and out_mod are stable while out_valid=1 and out_ready=0.
- in_ready depends only on registered state, with no combinational path from out_ready.

## Configuration
- WIMAX_INTLV_BYPASS_EN defined:
  - Adds an input port `bypass` (1 bit), latched with mod_sel at k=0.
  - A block latched with bypass=1 is stored at j=k, so the output order equals the input order.
  - All handshake and latency behaviour is unchanged.
- Not defined: the port is absent and the permutation is always applied.

## Test plan
- QPSK permutation: stream a 192-bit block with only bit k=1 set, out_ready=1 → out_valid rises the cycle after the last input; only output index 12 is 1; out_last on index 191.
- 16-QAM permutation: a 384-bit block with only k=1 set → only output index 25 is 1. With only k=0 set → output index 0.
- 64-QAM permutation: a 576-bit block with only k=1 set → only output index 38 is 1. A block carrying a bijection check (k as data, across passes) confirms every j is hit exactly once.
- Back-pressure: out_ready=0 while three blocks are offered → in_ready drops after the second block is accepted. Raising out_ready → in_ready returns 1 one cycle after the first out_last transfer. No data is lost or reordered.
- Mode switch: toggle mod_sel mid-block (QPSK → 64-QAM at k=100) → block stays 192 bits, out_mod=00. The next block is 576 bits with out_mod=10.
- Reset mid-operation: assert reset at k=50 of a block with one full bank pending → next cycle out_valid=0, in_ready=1, out_data=0. A fresh block then behaves as first-block latency.
